// File: rtl/serial_addsub_seq.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, using two half adders and a carry register.
// Latency: start sampled at edge E, busy for the next WIDTH cycles, then a one-cycle done pulse (period WIDTH+2).
// Backpressure: none; start is honoured only in IDLE, and requests made while busy or done are dropped.
module serial_addsub_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic            carry;
    logic [CW-1:0]   cnt;

    // Bit slice: two cascaded half adders on the current LSBs and the carry register.
    logic h1s;
    logic h1c;
    logic s_bit;
    logic h2c;
    logic carry_nxt;

    // Bit-slice arithmetic for the current operand LSBs.
    always_comb begin
        h1s       = op_a[0] ^ op_b[0];
        h1c       = op_a[0] & op_b[0];
        s_bit     = h1s ^ carry;
        h2c       = h1s & carry;
        carry_nxt = h1c | h2c;
    end

    // Control FSM plus the operand, sum and carry datapath registers, with registered busy/done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1; the +1 enters through the carry register.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry <= carry_nxt;
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        cout  <= carry_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Start is ignored here; a held start re-accepts on the next IDLE edge.
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Self-checking bench for serial_addsub_seq: directed cases plus randomized operations.
// Outputs are compared each cycle against a timeline model driven by plain arithmetic.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_serial_addsub_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int errors = 0;
    int checks = 0;

    serial_addsub_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts cycles since the accepting edge (0 = idle).
    int           k = 0;
    bit           model_valid = 0;
    logic [W-1:0] la, lb;
    logic         ls;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    int           cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            k = 0;
            m_sum = '0;
            m_cout = 1'b0;
            model_valid = 1;
        end else if (k == 0) begin
            if (start) begin
                la = a; lb = b; ls = sub;
                m_sum = '0; m_cout = 1'b0;
                k = 1;
            end
        end else if (k == W) begin
            if (ls) begin
                m_sum  = W'(int'(la) - int'(lb));
                m_cout = (la >= lb);
            end else begin
                m_sum  = W'(int'(la) + int'(lb));
                m_cout = ((int'(la) + int'(lb)) >= (1 << W));
            end
            k = W + 1;
        end else if (k == W + 1) begin
            k = 0;
        end else begin
            k++;
        end
    end

    // Compare process and done bookkeeping.
    int done_cnt = 0;
    int done_cyc_q[$];
    logic [W-1:0] done_sum_q[$];

    always @(negedge clk) begin
        if (model_valid) begin
            check("busy", busy, (k >= 1 && k <= W));
            check("done", done, (k == W + 1));
            if (!(k >= 1 && k <= W)) begin
                check("sum", sum, m_sum);
                check("cout", cout, m_cout);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
            done_sum_q.push_back(sum);
        end
    end

    // One operation: present operands for one edge, optionally scramble inputs while busy.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                          input bit noise, output logic [W-1:0] s_o, output logic c_o,
                          output int n_o);
        int n = 0;
        @(posedge clk); #1;
        a = ai; b = bi; sub = si; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (noise && done !== 1'b1) begin
                a = W'($urandom); b = W'($urandom);
                sub = 1'($urandom); start = 1'($urandom);
            end
        end
        start = 1'b0;
        check("done_seen", done, 1);
        s_o = sum; c_o = cout; n_o = n;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] rs;
    logic         rc;
    int           rn;
    int           d0;
    int           q0;

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);

        // Case 1: add with 8 busy cycles then done.
        run_op(8'h35, 8'h4A, 1'b0, 0, rs, rc, rn);
        check("c1_sum", rs, 8'h7F);
        check("c1_cout", rc, 0);
        check("c1_latency", rn, W + 1);

        // Case 2: wrap-around additions.
        run_op(8'hFF, 8'h01, 1'b0, 0, rs, rc, rn);
        check("c2a_sum", rs, 8'h00);
        check("c2a_cout", rc, 1);
        run_op(8'hFF, 8'hFF, 1'b0, 0, rs, rc, rn);
        check("c2b_sum", rs, 8'hFE);
        check("c2b_cout", rc, 1);

        // Case 3: subtraction with and without borrow.
        run_op(8'h10, 8'h01, 1'b1, 0, rs, rc, rn);
        check("c3a_sum", rs, 8'h0F);
        check("c3a_cout", rc, 1);
        run_op(8'h01, 8'h02, 1'b1, 0, rs, rc, rn);
        check("c3b_sum", rs, 8'hFF);
        check("c3b_cout", rc, 0);

        // Case 4: start pulse with new operands during RUN is dropped.
        d0 = done_cnt;
        @(posedge clk); #1;
        a = 8'h35; b = 8'h4A; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;             // accepting edge
        start = 1'b0;
        @(posedge clk); #1;             // now in RUN cycle 2
        @(posedge clk); #1;             // now in RUN cycle 3
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        check("c4_sum", sum, 8'h7F);
        check("c4_done_pulses", done_cnt - d0, 1);

        // Case 5: one-edge reset in RUN cycle 4 aborts the operation.
        @(posedge clk); #1;
        a = 8'h35; b = 8'h4A; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        check("c5_busy", busy, 0);
        check("c5_sum", sum, 0);
        check("c5_cout", cout, 0);
        repeat (15) @(posedge clk);
        check("c5_no_done", done_cnt - d0, 0);
        run_op(8'h10, 8'h01, 1'b1, 0, rs, rc, rn);
        check("c5_after_sum", rs, 8'h0F);
        check("c5_after_cout", rc, 1);

        // Case 6: start held high across three operand pairs.
        q0 = done_cyc_q.size();
        @(posedge clk); #1;
        a = 8'h35; b = 8'h4A; sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin a = 8'hFF; b = 8'h01; sub = 1'b0; end
            else if (i == 1) begin a = 8'h10; b = 8'h01; sub = 1'b1; end
            else start = 1'b0;
            if (i < 2) repeat (9) @(posedge clk);
        end
        repeat (14) @(posedge clk);
        check("c6_pulses", done_cyc_q.size() - q0, 3);
        if (done_cyc_q.size() - q0 >= 3) begin
            check("c6_gap1", done_cyc_q[q0 + 1] - done_cyc_q[q0], 10);
            check("c6_gap2", done_cyc_q[q0 + 2] - done_cyc_q[q0 + 1], 10);
            check("c6_sum0", done_sum_q[q0], 8'h7F);
            check("c6_sum1", done_sum_q[q0 + 1], 8'h00);
            check("c6_sum2", done_sum_q[q0 + 2], 8'h0F);
        end

        // Randomized operations with input noise while busy and random idle gaps.
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), rs, rc, rn);
            check("rnd_latency", rn, W + 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
